// File: rtl/cos_sim_pkg.sv
// Shared types and helpers for the streaming cosine-similarity accumulator.
//   cos_sim_state_t : control FSM states (RUN / DRAIN / HOLD)
//   acc_width()     : accumulator width for a given element width and vector length
//   lane_lsb()      : bit offset of a lane inside a packed beat
package cos_sim_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } cos_sim_state_t;

  // Cycles spent flushing the multiply and accumulate stages after the last beat.
  localparam int unsigned DRAIN_CYCLES = 2;

  // 2*ew covers one product; clog2(n) covers the sum of n products; the extra
  // bit keeps the signed dot product range (+/- n*2^(2ew-2)) representable.
  function automatic int unsigned acc_width(input int unsigned ew, input int unsigned n);
    return 2 * ew + int'($clog2(n)) + 1;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned ew);
    return lane * ew;
  endfunction

endpackage

// File: rtl/cos_sim_lane_mul.sv
// One lane of the first pipeline stage: registers A*A, B*B and A*B.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   flush        : synchronous abort, zeroes the registered products
//   load         : capture the products of the current beat
//   mode         : 1 = operands are two's complement, 0 = unsigned
//   a, b         : lane elements
//   sq_a, sq_b   : registered squares (always non-negative, 2*EW bits)
//   dot          : registered A*B (two's complement in signed mode, 2*EW bits)
module cos_sim_lane_mul #(
  parameter int unsigned EW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic            mode,
  input  logic [EW-1:0]   a,
  input  logic [EW-1:0]   b,
  output logic [2*EW-1:0] sq_a,
  output logic [2*EW-1:0] sq_b,
  output logic [2*EW-1:0] dot
);

  localparam int unsigned PW = 2 * EW;

  logic [PW-1:0] a_ext_c;
  logic [PW-1:0] b_ext_c;
  logic [PW-1:0] sq_a_d, sq_a_q;
  logic [PW-1:0] sq_b_d, sq_b_q;
  logic [PW-1:0] dot_d,  dot_q;

  // Extend operands to product width; the low PW bits of a PW x PW product are
  // exact because every square and cross product fits in PW bits for either mode.
  always_comb begin
    a_ext_c = PW'($signed({mode & a[EW-1], a}));
    b_ext_c = PW'($signed({mode & b[EW-1], b}));
    sq_a_d  = sq_a_q;
    sq_b_d  = sq_b_q;
    dot_d   = dot_q;
    if (flush) begin
      sq_a_d = '0;
      sq_b_d = '0;
      dot_d  = '0;
    end else if (load) begin
      sq_a_d = a_ext_c * a_ext_c;
      sq_b_d = b_ext_c * b_ext_c;
      dot_d  = a_ext_c * b_ext_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_a_q <= '0;
      sq_b_q <= '0;
      dot_q  <= '0;
    end else begin
      sq_a_q <= sq_a_d;
      sq_b_q <= sq_b_d;
      dot_q  <= dot_d;
    end
  end

  assign sq_a = sq_a_q;
  assign sq_b = sq_b_q;
  assign dot  = dot_q;

endmodule

// File: rtl/cosine_similarity_stream.sv
// Streaming cosine-similarity accumulator. Takes two vectors of NUM_ELEMENTS
// elements, LANES per beat, and produces sum(A^2), sum(B^2) and sum(A*B),
// held until the downstream stage accepts them.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   clear                 : synchronous abort, drops any partial or held result
//   signed_mode           : element interpretation, latched on the first beat
//   in_valid / in_ready   : input beat handshake
//   A, B                  : packed beats, lane i at [i*EW +: EW]
//   out_valid / out_ready : result handshake
//   SmodA, SmodB          : unsigned sums of squares
//   Sdot                  : dot product (two's complement in signed mode)
module cosine_similarity_stream
  import cos_sim_pkg::*;
#(
  parameter  int unsigned ELEMENT_WIDTH = 8,
  parameter  int unsigned LANES         = 4,
  parameter  int unsigned NUM_ELEMENTS  = 64,
  localparam int unsigned ACC_WIDTH     = acc_width(ELEMENT_WIDTH, NUM_ELEMENTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           signed_mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES*ELEMENT_WIDTH-1:0] A,
  input  logic [LANES*ELEMENT_WIDTH-1:0] B,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           SmodA,
  output logic [ACC_WIDTH-1:0]           SmodB,
  output logic [ACC_WIDTH-1:0]           Sdot
);

  localparam int unsigned NUM_BEATS = NUM_ELEMENTS / LANES;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned PW        = 2 * ELEMENT_WIDTH;

  if ((LANES == 0) || (NUM_ELEMENTS % LANES != 0)) begin : g_cfg_err
    $error("cosine_similarity_stream: NUM_ELEMENTS must be a non-zero multiple of LANES");
  end

  cos_sim_state_t state_q, state_d;

  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 drain_cnt_q, drain_cnt_d;
  logic                 mode_q, mode_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [ACC_WIDTH-1:0] acc_a_q, acc_a_d;
  logic [ACC_WIDTH-1:0] acc_b_q, acc_b_d;
  logic [ACC_WIDTH-1:0] acc_dot_q, acc_dot_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic                 beat_hs_c;
  logic                 out_hs_c;
  logic                 last_beat_c;
  logic                 lane_mode_c;
  logic [ACC_WIDTH-1:0] sum_a_c, sum_b_c, sum_dot_c;

  logic [PW-1:0] sq_a_w [LANES];
  logic [PW-1:0] sq_b_w [LANES];
  logic [PW-1:0] dot_w  [LANES];

  assign beat_hs_c   = in_valid & in_ready_q;
  assign out_hs_c    = out_ready & out_valid_q;
  assign last_beat_c = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
  // The first beat must use the live mode bit; later beats use the latched copy.
  assign lane_mode_c = (beat_cnt_q == '0) ? signed_mode : mode_q;

  // Stage 1: per-lane multipliers.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cos_sim_lane_mul #(
      .EW(ELEMENT_WIDTH)
    ) u_mul (
      .clk  (clk),
      .reset(reset),
      .flush(clear),
      .load (beat_hs_c),
      .mode (lane_mode_c),
      .a    (A[lane_lsb(i, ELEMENT_WIDTH) +: ELEMENT_WIDTH]),
      .b    (B[lane_lsb(i, ELEMENT_WIDTH) +: ELEMENT_WIDTH]),
      .sq_a (sq_a_w[i]),
      .sq_b (sq_b_w[i]),
      .dot  (dot_w[i])
    );
  end

  // Stage 2 lane reduction; only the dot product needs sign extension.
  always_comb begin
    sum_a_c   = '0;
    sum_b_c   = '0;
    sum_dot_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_a_c = sum_a_c + ACC_WIDTH'(sq_a_w[i]);
      sum_b_c = sum_b_c + ACC_WIDTH'(sq_b_w[i]);
      if (mode_q) begin
        sum_dot_c = sum_dot_c + ACC_WIDTH'($signed(dot_w[i]));
      end else begin
        sum_dot_c = sum_dot_c + ACC_WIDTH'(dot_w[i]);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN:     if (beat_hs_c && last_beat_c) state_d = DRAIN;
        DRAIN:   if (drain_cnt_q == 1'(DRAIN_CYCLES - 1)) state_d = HOLD;
        HOLD:    if (out_hs_c) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Counters, accumulators and registered handshake outputs.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = 1'b0;
    mode_d      = mode_q;
    s1_valid_d  = 1'b0;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    acc_dot_d   = acc_dot_q;
    in_ready_d  = (state_d == RUN);
    out_valid_d = (state_d == HOLD);
    if (clear) begin
      beat_cnt_d = '0;
      mode_d     = 1'b0;
      acc_a_d    = '0;
      acc_b_d    = '0;
      acc_dot_d  = '0;
    end else begin
      s1_valid_d = beat_hs_c;
      if (beat_hs_c) begin
        if (beat_cnt_q == '0) mode_d = signed_mode;
        beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + CNT_W'(1);
      end
      if (state_q == DRAIN) drain_cnt_d = drain_cnt_q + 1'b1;
      // A stage-1 beat never coincides with the result handshake, so the two
      // accumulator updates are mutually exclusive.
      if (s1_valid_q) begin
        acc_a_d   = acc_a_q + sum_a_c;
        acc_b_d   = acc_b_q + sum_b_c;
        acc_dot_d = acc_dot_q + sum_dot_c;
      end else if (out_hs_c) begin
        acc_a_d   = '0;
        acc_b_d   = '0;
        acc_dot_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      mode_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      acc_dot_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      acc_dot_q   <= acc_dot_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign SmodA     = acc_a_q;
  assign SmodB     = acc_b_q;
  assign Sdot      = acc_dot_q;

endmodule

// File: tb/tb_cosine_similarity_stream.sv
// Bench for cosine_similarity_stream: directed table vectors, randomized
// vectors against an arithmetic reference, flow-control and abort sequences,
// plus a single-beat-per-vector instance run back to back.
module tb_cosine_similarity_stream;

  localparam int unsigned EW  = 8;
  localparam int unsigned L   = 4;
  localparam int unsigned N   = 64;
  localparam int unsigned NB  = N / L;
  localparam int unsigned AW  = 23;
  localparam int unsigned AW4 = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, clear, signed_mode, in_valid, out_ready;
  logic [L*EW-1:0] A, B;
  logic            in_ready, out_valid;
  logic [AW-1:0]   SmodA, SmodB, Sdot;

  logic            clear4, signed_mode4, in_valid4, out_ready4;
  logic [L*EW-1:0] A4, B4;
  logic            in_ready4, out_valid4;
  logic [AW4-1:0]  SmodA4, SmodB4, Sdot4;

  cosine_similarity_stream #(.ELEMENT_WIDTH(EW), .LANES(L), .NUM_ELEMENTS(N)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .SmodA(SmodA), .SmodB(SmodB), .Sdot(Sdot)
  );

  cosine_similarity_stream #(.ELEMENT_WIDTH(EW), .LANES(L), .NUM_ELEMENTS(L)) u_dut4 (
    .clk(clk), .reset(reset), .clear(clear4), .signed_mode(signed_mode4),
    .in_valid(in_valid4), .in_ready(in_ready4), .A(A4), .B(B4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .SmodA(SmodA4), .SmodB(SmodB4), .Sdot(Sdot4)
  );

  typedef struct {
    logic          sm;
    logic          ramp;
    logic [EW-1:0] av;
    logic [EW-1:0] bv;
    logic [AW-1:0] ea;
    logic [AW-1:0] eb;
    logic [AW-1:0] ed;
  } vec_t;

  typedef struct packed {
    logic [AW4-1:0] a;
    logic [AW4-1:0] b;
    logic [AW4-1:0] d;
  } res4_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] va [N];
  logic [EW-1:0] vb [N];
  logic          vm [NB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic logic [L*EW-1:0] pack_beat(input logic [EW-1:0] v [N], input int bt);
    logic [L*EW-1:0] p;
    for (int l = 0; l < L; l++) p[l*EW +: EW] = v[bt*L + l];
    return p;
  endfunction

  // Reference: plain integer sums over one beat under a given interpretation.
  task automatic lane_sums(input logic [L*EW-1:0] a, input logic [L*EW-1:0] b, input logic sm,
                           output longint sa, output longint sb, output longint sd);
    sa = 0; sb = 0; sd = 0;
    for (int l = 0; l < L; l++) begin
      logic [EW-1:0] ea, eb;
      longint x, y;
      ea = a[l*EW +: EW];
      eb = b[l*EW +: EW];
      x  = sm ? longint'($signed(ea)) : longint'(ea);
      y  = sm ? longint'($signed(eb)) : longint'(eb);
      sa += x * x;
      sb += y * y;
      sd += x * y;
    end
  endtask

  // Whole-vector reference; the mode of beat 0 governs the vector.
  task automatic model_vec(output logic [AW-1:0] ea, output logic [AW-1:0] eb, output logic [AW-1:0] ed);
    longint ta, tb, td, sa, sb, sd;
    ta = 0; tb = 0; td = 0;
    for (int bt = 0; bt < int'(NB); bt++) begin
      lane_sums(pack_beat(va, bt), pack_beat(vb, bt), vm[0], sa, sb, sd);
      ta += sa; tb += sb; td += sd;
    end
    ea = AW'(ta); eb = AW'(tb); ed = AW'(td);
  endtask

  // Returns at the posedge where the beat is accepted.
  task automatic send_beat(input logic [L*EW-1:0] a, input logic [L*EW-1:0] b, input logic sm);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; signed_mode = sm;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      timeout_fail("beat_accept");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid    = 1'b0;
      A           = L*EW'($urandom);
      signed_mode = 1'($urandom);
    end
  endtask

  // Ends at the negedge of the first cycle after the last beat handshake.
  task automatic send_vector(input int max_gap);
    for (int bt = 0; bt < int'(NB); bt++) begin
      send_beat(pack_beat(va, bt), pack_beat(vb, bt), vm[bt]);
      if (max_gap > 0 && bt != int'(NB) - 1) idle(int'($urandom_range(max_gap, 0)));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [AW-1:0] ea, input logic [AW-1:0] eb,
                            input logic [AW-1:0] ed);
    int guard;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      timeout_fail({name, "_out_valid"});
    end else begin
      check({name, "_SmodA"}, 64'(SmodA), 64'(ea));
      check({name, "_SmodB"}, 64'(SmodB), 64'(eb));
      check({name, "_Sdot"},  64'(Sdot),  64'(ed));
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_in_ready_after_accept"}, 64'(in_ready), 64'd1);
      check({name, "_out_valid_after_accept"}, 64'(out_valid), 64'd0);
    end
  endtask

  task automatic check_latency(input string name);
    check({name, "_ov_T+1"}, 64'(out_valid), 64'd0);
    check({name, "_ir_T+1"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({name, "_ov_T+2"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "_ov_T+3"}, 64'(out_valid), 64'd1);
  endtask

  task automatic rand_vec(input logic first_mode);
    for (int i = 0; i < int'(N); i++) begin
      va[i] = EW'($urandom);
      vb[i] = EW'($urandom);
    end
    for (int bt = 0; bt < int'(NB); bt++) vm[bt] = 1'($urandom);
    vm[0] = first_mode;
  endtask

  task automatic fill_const(input logic sm, input logic [EW-1:0] a, input logic [EW-1:0] b);
    for (int i = 0; i < int'(N); i++) begin
      va[i] = a;
      vb[i] = b;
    end
    for (int bt = 0; bt < int'(NB); bt++) vm[bt] = sm;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [7];
    logic [AW-1:0] ea, eb, ed;
    res4_t         q4 [$];
    res4_t         r4;
    int            last_cyc, nres;
    longint        sa, sb, sd;

    tbl[0] = '{sm:1'b0, ramp:1'b1, av:8'd0,   bv:8'd2,   ea:23'd1632,    eb:23'd256,     ed:23'd576};
    tbl[1] = '{sm:1'b1, ramp:1'b0, av:8'h80,  bv:8'h7F,  ea:23'd1048576, eb:23'd1032256, ed:23'(-1040384)};
    tbl[2] = '{sm:1'b0, ramp:1'b0, av:8'd1,   bv:8'd1,   ea:23'd64,      eb:23'd64,      ed:23'd64};
    tbl[3] = '{sm:1'b0, ramp:1'b0, av:8'd255, bv:8'd255, ea:23'd4161600, eb:23'd4161600, ed:23'd4161600};
    tbl[4] = '{sm:1'b1, ramp:1'b0, av:8'hFF,  bv:8'd1,   ea:23'd64,      eb:23'd64,      ed:23'(-64)};
    tbl[5] = '{sm:1'b1, ramp:1'b0, av:8'hFF,  bv:8'hFF,  ea:23'd64,      eb:23'd64,      ed:23'd64};
    tbl[6] = '{sm:1'b1, ramp:1'b0, av:8'h80,  bv:8'h80,  ea:23'd1048576, eb:23'd1048576, ed:23'd1048576};

    reset = 1'b1; clear = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0;
    clear4 = 1'b0; signed_mode4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    A4 = '0; B4 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_SmodA",     64'(SmodA),     64'd0);
    check("reset_SmodB",     64'(SmodB),     64'd0);
    check("reset_Sdot",      64'(Sdot),      64'd0);
    check("reset_in_ready4", 64'(in_ready4), 64'd1);

    // Directed vectors with exact result latency.
    for (int t = 0; t < 7; t++) begin
      fill_const(tbl[t].sm, tbl[t].av, tbl[t].bv);
      if (tbl[t].ramp) for (int i = 0; i < int'(N); i++) va[i] = EW'(i % 8 + 1);
      send_vector(0);
      check_latency($sformatf("tbl%0d", t));
      get_result($sformatf("tbl%0d", t), tbl[t].ea, tbl[t].eb, tbl[t].ed);
    end

    // Random gaps, mode bit toggled on later beats and during gaps.
    for (int r = 0; r < 6; r++) begin
      rand_vec(1'(r));
      model_vec(ea, eb, ed);
      send_vector(3);
      get_result($sformatf("rand%0d", r), ea, eb, ed);
    end

    // Result backpressure with input offered while holding.
    rand_vec(1'b1);
    model_vec(ea, eb, ed);
    send_vector(0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", k),  64'(in_ready),  64'd0);
      check($sformatf("bp%0d_SmodA", k),     64'(SmodA),     64'(ea));
      check($sformatf("bp%0d_Sdot", k),      64'(Sdot),      64'(ed));
      @(negedge clk);
      in_valid = 1'b1;
      A = L*EW'($urandom);
      B = L*EW'($urandom);
    end
    in_valid = 1'b0;
    get_result("bp_release", ea, eb, ed);
    rand_vec(1'b0);
    model_vec(ea, eb, ed);
    send_vector(1);
    get_result("bp_next", ea, eb, ed);

    // Abort after three beats, then a clean all-ones vector.
    rand_vec(1'b1);
    for (int bt = 0; bt < 3; bt++) send_beat(pack_beat(va, bt), pack_beat(vb, bt), vm[bt]);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_in_ready",  64'(in_ready),  64'd1);
    check("clear_out_valid", 64'(out_valid), 64'd0);
    check("clear_SmodA",     64'(SmodA),     64'd0);
    check("clear_Sdot",      64'(Sdot),      64'd0);
    fill_const(1'b0, 8'd1, 8'd1);
    send_vector(0);
    check_latency("after_clear");
    get_result("after_clear", 23'd64, 23'd64, 23'd64);

    // Reset while draining.
    fill_const(1'b0, 8'd2, 8'd3);
    send_vector(0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_drain_in_ready",  64'(in_ready),  64'd1);
    check("rst_drain_out_valid", 64'(out_valid), 64'd0);
    check("rst_drain_SmodA",     64'(SmodA),     64'd0);
    check("rst_drain_SmodB",     64'(SmodB),     64'd0);
    check("rst_drain_Sdot",      64'(Sdot),      64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_drain_quiet%0d", k), 64'(out_valid), 64'd0);
    end
    rand_vec(1'b1);
    model_vec(ea, eb, ed);
    send_vector(0);
    get_result("after_reset", ea, eb, ed);

    // Single-beat vectors, input always offered, output always accepted.
    last_cyc = -1;
    nres     = 0;
    out_ready4 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (out_valid4) begin
        if (q4.size() == 0) begin
          timeout_fail("dut4_unexpected_result");
        end else begin
          r4 = q4.pop_front();
          check($sformatf("dut4_r%0d_SmodA", nres), 64'(SmodA4), 64'(r4.a));
          check($sformatf("dut4_r%0d_SmodB", nres), 64'(SmodB4), 64'(r4.b));
          check($sformatf("dut4_r%0d_Sdot", nres),  64'(Sdot4),  64'(r4.d));
        end
        if (last_cyc >= 0) check($sformatf("dut4_r%0d_spacing", nres), 64'(cyc - last_cyc), 64'd4);
        last_cyc = cyc;
        nres++;
      end
      in_valid4    = 1'b1;
      A4           = L*EW'($urandom);
      B4           = L*EW'($urandom);
      signed_mode4 = 1'($urandom);
      if (in_ready4) begin
        lane_sums(A4, B4, signed_mode4, sa, sb, sd);
        q4.push_back('{a: AW4'(sa), b: AW4'(sb), d: AW4'(sd)});
      end
    end
    @(negedge clk);
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    check("dut4_result_count", 64'(nres), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cosine_similarity_stream.md
# cosine_similarity_stream

Streaming, multi-lane successor to the fixed single-shot cosine-similarity core. Consumes two vectors of `NUM_ELEMENTS` elements, `LANES` elements per beat, under valid/ready flow control. Accumulates |A|², |B|² and A·B with selectable signed/unsigned arithmetic, then presents all three sums until the downstream normaliser/comparator in the similarity path accepts them.

## Interface
Parameters:
- `ELEMENT_WIDTH`, 8: bits per element.
- `LANES`, 4: elements per beat. `NUM_ELEMENTS` must be a multiple of `LANES`; elaboration error otherwise.
- `NUM_ELEMENTS`, 64: elements per vector. `NUM_BEATS = NUM_ELEMENTS/LANES`.
- `ACC_WIDTH`, derived: `2*ELEMENT_WIDTH + $clog2(NUM_ELEMENTS) + 1`.

Ports:
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous abort; discards any partial vector.
- `signed_mode`  in  1  1 = two's-complement elements; sampled on the first beat of each vector.
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  block accepts a beat.
- `A`  in  LANES*ELEMENT_WIDTH  lane i at bits [i*EW +: EW]; element index = beat*LANES + i.
- `B`  in  LANES*ELEMENT_WIDTH  same packing as `A`.
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  downstream accepts results.
- `SmodA`  out  ACC_WIDTH  Σ A², unsigned.
- `SmodB`  out  ACC_WIDTH  Σ B², unsigned.
- `Sdot`  out  ACC_WIDTH  Σ A·B; two's complement in signed mode, unsigned otherwise.

## Operation
- FSM states: `RUN`, `DRAIN`, `HOLD`. Reset state is `RUN` with beat count 0.
- `RUN`: `in_ready`=1. Each handshake (`in_valid & in_ready`) increments the beat counter. On the beat with count `NUM_BEATS-1`, the counter wraps to 0 and the FSM goes to `DRAIN`.
- `DRAIN`: `in_ready`=0 while the 2-stage pipeline flushes. After 2 cycles the FSM goes to `HOLD`.
- `HOLD`: `out_valid`=1. Outputs and `out_valid` stay stable until `out_ready`=1. On that handshake the accumulators clear and the FSM goes to `RUN`.
- Pipeline stage 1: per lane, register A², B² and A·B at width 2*EW, sign- or zero-extended per the latched `signed_mode`.
- Pipeline stage 2: lane adder tree plus accumulate.
- Arithmetic never overflows for any input, including all elements = -2^(EW-1) in signed mode.
- `signed_mode` is latched on the first beat of each vector. Changes mid-vector are ignored.
- `in_valid` while `in_ready`=0 is ignored. `out_ready` while `out_valid`=0 is ignored.
- `clear` and `reset` both return the block to `RUN`, count 0, accumulators 0, pipeline valid bits 0, `out_valid`=0. `reset` has priority over `clear`. `clear` in `HOLD` drops the unaccepted result.
- `LANES == NUM_ELEMENTS` is legal: a single beat goes `RUN` → `DRAIN`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `SmodA`=`SmodB`=`Sdot`=0.
- Last beat handshake at cycle T: `out_valid` is high from cycle T+3. Beat T is in stage 1 at T+1 and in the accumulator at T+2; `HOLD` starts at T+3.
- Output handshake at cycle H: `in_ready`=1 at cycle H+1.
- Minimum period per vector: `NUM_BEATS + 3` cycles.
- Inputs may stall between beats arbitrarily. Bubbles do not affect results.

## Structure
- Package `cos_sim_pkg` holds:
  - the state enum `cos_sim_state_t`;
  - the function `acc_width(ew, n)`;
  - the lane-slicing helper.
- Sub-module `cos_sim_lane_mul` (one instance per lane) contains stage 1: three multipliers plus extension on the mode bit.
- The top level holds the FSM, beat counter, adder tree and accumulators.

## Test plan
- Unsigned, EW=8, LANES=4, N=8; A=1..8, B all 2 -> `SmodA`=204, `SmodB`=32, `Sdot`=72; `out_valid` at T+3.
- Signed, all A=-128, all B=127, N=64 -> `SmodA`=1048576, `SmodB`=1032256, `Sdot`=-1040384 (two's complement, ACC_WIDTH=23).
- Backpressure: hold `out_ready`=0 for 10 cycles -> outputs stable, `in_ready`=0 throughout. Release -> `in_ready`=1 next cycle; the next vector is independent.
- Random `in_valid` gaps plus `signed_mode` toggled mid-vector -> results match the mode latched on beat 0.
- `clear` after 3 of 16 beats, then a full vector A=B=1 -> `SmodA`=`SmodB`=`Sdot`=64 (N=64). Repeat with `reset` mid-`DRAIN` -> all outputs 0, `in_ready`=1 next cycle.
- LANES=N=4, back-to-back vectors with `out_ready` tied high -> one result every 4 cycles, matching the reference model.
